// File: rtl/snn_layer_sched.sv
// snn_layer_sched: time-multiplexed integrate-and-fire layer.
// One shared datapath walks the neurons in index order, one per cycle, for
// each accepted 4-bit input spike vector. A neuron fires on the rising edge
// of its potential's sign bit; firing zeroes the potential and discards that
// step's input.
module snn_layer_sched #(
  parameter int WEIGHT_WIDTH = 4,
  parameter int N_NEURONS    = 4
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              cfg_we,
  input  logic [$clog2(N_NEURONS)+2-1:0]    cfg_addr,
  input  logic signed [WEIGHT_WIDTH-1:0]    cfg_data,
  input  logic                              clr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [3:0]                        in_spikes,
  output logic                              out_valid,
  output logic [N_NEURONS-1:0]              out_spikes,
  output logic [7:0]                        ts_count
);

  localparam int NIDX_W = $clog2(N_NEURONS);
  localparam int ADDR_W = NIDX_W + 2;
  localparam logic [NIDX_W-1:0] LAST_IDX = NIDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [NIDX_W-1:0]        idx_reg;
  logic [3:0]               spikes_reg;
  logic [7:0]               ts_count_reg;
  logic                     accept;
  logic                     cfg_wr_en;

  logic signed [WEIGHT_WIDTH-1:0] w_all [N_NEURONS][4];
  logic signed [5:0]              pot_all [N_NEURONS];
  logic [N_NEURONS-1:0]           msb_all;
  logic signed [5:0]              term [4];
  logic signed [5:0]              sum_c;
  logic signed [5:0]              pot_cur;
  logic                           fire_c;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and handshake outputs; clr in IDLE has priority over accept
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = ~clr;
        if (in_valid && !clr) begin
          accept     = 1'b1;
          state_next = PROC;
        end
      end
      PROC: begin
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the spike vector on accept and step the neuron index through PROC
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idx_reg    <= '0;
      spikes_reg <= '0;
    end else if (accept) begin
      idx_reg    <= '0;
      spikes_reg <= in_spikes;
    end else if (state_reg == PROC) begin
      idx_reg    <= idx_reg + NIDX_W'(1);
    end
  end

  // Completed-timestep counter, wraps naturally at 8 bits
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                  ts_count_reg <= '0;
    else if (state_reg == DONE) ts_count_reg <= ts_count_reg + 8'd1;
  end

  assign ts_count  = ts_count_reg;
  assign cfg_wr_en = cfg_we && (state_reg == IDLE);

  // Shared datapath: weighted sum of the active synapses of the current neuron
  genvar gi, gk;
  generate
    for (gk = 0; gk < 4; gk++) begin : g_term
      assign term[gk] = spikes_reg[gk] ? 6'(w_all[idx_reg][gk]) : 6'sd0;
    end
  endgenerate

  assign sum_c   = term[0] + term[1] + term[2] + term[3];
  assign pot_cur = pot_all[idx_reg];
  assign fire_c  = pot_cur[5] & ~msb_all[idx_reg];

  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
      logic signed [5:0] pot_reg;
      logic              msb_reg;
      logic              spk_reg;
      logic              hit;

      assign hit = (state_reg == PROC) && (idx_reg == NIDX_W'(gi));

      // Neuron state: cleared by clr in IDLE, updated when its slot comes up in PROC
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          pot_reg <= '0;
          msb_reg <= 1'b0;
          spk_reg <= 1'b0;
        end else if (state_reg == IDLE && clr) begin
          pot_reg <= '0;
          msb_reg <= 1'b0;
        end else if (hit) begin
          msb_reg <= pot_reg[5];
          spk_reg <= fire_c;
          pot_reg <= fire_c ? 6'sd0 : pot_reg + sum_c;
        end
      end

      assign pot_all[gi]    = pot_reg;
      assign msb_all[gi]    = msb_reg;
      assign out_spikes[gi] = spk_reg;

      for (gk = 0; gk < 4; gk++) begin : g_syn
        logic signed [WEIGHT_WIDTH-1:0] w_reg;

        // Weight storage; address decode only matches existing neurons
        always_ff @(posedge CLK or negedge nRST) begin
          if (!nRST)
            w_reg <= '0;
          else if (cfg_wr_en && cfg_addr == ADDR_W'(gi * 4 + gk))
            w_reg <= cfg_data;
        end

        assign w_all[gi][gk] = w_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_snn_layer_sched.sv
// Testbench for snn_layer_sched: directed scenarios plus random traffic,
// checked every cycle against a timestep-level behavioural model.
module tb_snn_layer_sched;
  localparam int WW = 4;
  localparam int N  = 4;
  localparam int AW = $clog2(N) + 2;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [WW-1:0] cfg_data = '0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_spikes = '0;
  logic          out_valid;
  logic [N-1:0]  out_spikes;
  logic [7:0]    ts_count;

  snn_layer_sched #(.WEIGHT_WIDTH(WW), .N_NEURONS(N)) dut (
    .CLK(CLK), .nRST(nRST), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_spikes(in_spikes), .out_valid(out_valid), .out_spikes(out_spikes),
    .ts_count(ts_count)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  int       w_m [N][4];
  int       pot_m [N];
  bit       msb_m [N];
  bit [N-1:0] out_m;
  bit [N-1:0] out_pend;
  int       busy;          // cycles elapsed since accept, 0 when idle
  int       ts_m;
  bit       accepted_now;
  int       n_checks = 0;
  int       n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wrap64(int v);
    return ((v % 64) + 64) % 64;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pot_m[i] = 0;
      msb_m[i] = 1'b0;
      for (int k = 0; k < 4; k++) w_m[i][k] = 0;
    end
    out_m = '0; out_pend = '0; busy = 0; ts_m = 0; accepted_now = 1'b0;
  endtask

  // Whole timestep at once: every neuron's new potential and spike
  task automatic model_timestep(logic [3:0] sp);
    for (int i = 0; i < N; i++) begin
      int  sum;
      bit  neg, fire;
      sum = 0;
      for (int k = 0; k < 4; k++) if (sp[k]) sum += w_m[i][k];
      neg  = (pot_m[i] >= 32);
      fire = neg && !msb_m[i];
      msb_m[i] = neg;
      pot_m[i] = fire ? 0 : wrap64(pot_m[i] + sum);
      out_pend[i] = fire;
    end
  endtask

  task automatic model_edge();
    accepted_now = 1'b0;
    if (!nRST) return;
    if (busy == 0) begin
      if (cfg_we) begin
        int a, v;
        a = int'(cfg_addr);
        v = int'(cfg_data);
        if (v >= 2 ** (WW - 1)) v -= 2 ** WW;
        if ((a >> 2) < N) w_m[a >> 2][a % 4] = v;
      end
      if (clr) begin
        for (int i = 0; i < N; i++) begin pot_m[i] = 0; msb_m[i] = 1'b0; end
      end else if (in_valid) begin
        model_timestep(in_spikes);
        busy = 1;
        accepted_now = 1'b1;
      end
    end else if (busy <= N) begin
      busy++;
      if (busy == N + 1) out_m = out_pend;
    end else begin
      busy = 0;
      ts_m = (ts_m + 1) % 256;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK);
      chk("in_ready", int'(in_ready), int'(busy == 0 && !clr));
      chk("out_valid", int'(out_valid), int'(busy == N + 1));
      chk("ts_count", int'(ts_count), ts_m);
      if (busy == 0 || busy == N + 1)
        chk("out_spikes", int'(out_spikes), int'(out_m));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic cfg_write(int a, int d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = WW'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic apply_reset();
    cfg_we = 1'b0; clr = 1'b0; in_valid = 1'b0;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_spikes", int'(out_spikes), 0);
    chk("rst_ts_count", int'(ts_count), 0);
    tick(); tick();
    nRST = 1'b1;
  endtask

  task automatic run_ts(logic [3:0] sp, bit poke, int abort_after);
    int t;
    in_spikes = sp; in_valid = 1'b1; accepted_now = 1'b0; t = 0;
    while (!accepted_now && t < 20) begin tick(); t++; end
    in_valid = 1'b0;
    if (!accepted_now) begin chk("accept_timeout", 0, 1); return; end
    if (poke) begin
      cfg_we = 1'b1; cfg_addr = AW'(4); cfg_data = WW'(7); clr = 1'b1;
    end
    if (abort_after > 0) begin
      repeat (abort_after) tick();
      apply_reset();
      return;
    end
    t = 0;
    while (busy != 0 && t < 40) begin
      tick(); t++;
      if (busy == N + 1) begin cfg_we = 1'b0; clr = 1'b0; end
    end
    if (busy != 0) chk("done_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  int exp_pot32 [4] = '{28, 56, 0, 28};
  int exp_out32 [4] = '{0, 0, 1, 0};
  int exp_out35 [4] = '{0, 1, 0, 1};

  initial begin
    model_reset();
    nRST = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_spikes", int'(out_spikes), 0);

    // Positive weights on neuron 0: 28, 56, fire, 28
    for (int k = 0; k < 4; k++) cfg_write(k, 7);
    for (int s = 0; s < 4; s++) begin
      run_ts(4'b1111, 1'b0, 0);
      chk("w7_pot0", pot_m[0], exp_pot32[s]);
      chk("w7_out0", int'(out_spikes[0]), exp_out32[s]);
    end
    chk("ts_after_4", int'(ts_count), 4);

    // clr after two steps restarts neuron 0 from zero
    apply_reset();
    for (int k = 0; k < 4; k++) cfg_write(k, 7);
    run_ts(4'b1111, 1'b0, 0);
    run_ts(4'b1111, 1'b0, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_pot0", pot_m[0], 0);
    chk("clr_msb0", int'(msb_m[0]), 0);
    run_ts(4'b1111, 1'b0, 0);
    chk("clr_next_pot0", pot_m[0], 28);
    chk("clr_next_out0", int'(out_spikes[0]), 0);

    // Negative weight on neuron 1: 56 then fire
    apply_reset();
    cfg_write(4, -8);
    run_ts(4'b0001, 1'b0, 0);
    chk("neg_pot1_a", pot_m[1], 56);
    chk("neg_out1_a", int'(out_spikes[1]), 0);
    run_ts(4'b0001, 1'b0, 0);
    chk("neg_pot1_b", pot_m[1], 0);
    chk("neg_out1_b", int'(out_spikes[1]), 1);

    // Weight write and clr during PROC are ignored
    apply_reset();
    cfg_write(4, -8);
    for (int s = 0; s < 4; s++) begin
      run_ts(4'b0001, s == 0, 0);
      chk("proc_wr_out1", int'(out_spikes[1]), exp_out35[s]);
    end

    // Reset in the middle of PROC aborts the timestep
    run_ts(4'b1111, 1'b0, 2);
    run_ts(4'b1111, 1'b0, 0);
    chk("abort_out_spikes", int'(out_spikes), 0);
    chk("abort_ts", int'(ts_count), 1);

    // Random traffic
    for (int it = 0; it < 120; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)
        cfg_write($urandom_range(0, 2 ** AW - 1), $urandom_range(0, 2 ** WW - 1));
      else if (r == 3) begin
        clr = 1'b1; tick(); clr = 1'b0;
      end else
        run_ts(4'($urandom), $urandom_range(0, 4) == 0, 0);
    end
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snn_layer_sched.md
SNN_LAYER_SCHED -- requirements
Module: snn_layer_sched

Interface
REQ-001 Parameter WEIGHT_WIDTH, default 4: signed synaptic weight width.
REQ-002 Parameter N_NEURONS, default 4: number of neurons sharing one integrate/fire datapath; legal values 2, 4, 8.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 cfg_we  input  1  weight write strobe.
REQ-007 cfg_addr  input  clog2(N_NEURONS)+2  upper bits are neuron index, lower 2 bits are synapse index.
REQ-008 cfg_data  input  WEIGHT_WIDTH  signed weight value.
REQ-009 clr  input  1  request to clear all membrane state.
REQ-010 in_valid  input  1  timestep input spike vector valid.
REQ-011 in_ready  output  1  block accepts a timestep.
REQ-012 in_spikes  input  4  input spike vector, one bit per synapse.
REQ-013 out_valid  output  1  one-cycle pulse; out_spikes holds a new result.
REQ-014 out_spikes  output  N_NEURONS  output spikes from the last completed timestep, bit i = neuron i.
REQ-015 ts_count  output  8  number of completed timesteps, wraps 255->0.

Function
REQ-016 The block SHALL hold a weight array w[N_NEURONS][4], plus per-neuron pot[i] (6-bit signed) and msb_q[i] (1 bit).
REQ-017 FSM states: IDLE, PROC, DONE.
- IDLE->PROC on in_valid&&in_ready.
- PROC->DONE after neuron N_NEURONS-1 is processed.
- DONE->IDLE unconditionally after one cycle.
REQ-018 in_ready SHALL be 1 only in IDLE with clr=0.
REQ-019 On accept, the block SHALL latch in_spikes and set the neuron index to 0.
REQ-020 PROC SHALL process exactly one neuron per cycle, index 0 to N_NEURONS-1 in order.
- Accept at edge T: PROC occupies cycles T+1..T+N_NEURONS.
- out_valid is high in cycle T+N_NEURONS+1.
- in_ready returns in cycle T+N_NEURONS+2.
REQ-021 Per-neuron step i:
- fire = pot[i][5] && !msb_q[i].
- If fire, pot[i] <= 0; otherwise pot[i] <= pot[i] + sum.
- msb_q[i] <= pot[i][5] (value before the update).
- out_spikes bit i <= fire.
REQ-022 sum SHALL be the sum of w[i][k], each sign-extended to 6 bits, over every k where latched spike bit k = 1; 0 if no bits are set.
REQ-023 All potential arithmetic SHALL wrap modulo 64 with no saturation.
REQ-024 When fire=1, that step's input SHALL be discarded.
REQ-025 out_spikes SHALL update only in PROC; each bit holds its value until that neuron is next processed.
REQ-026 ts_count SHALL increment by 1 in DONE.
REQ-027 cfg_we writes w[neuron][synapse] <= cfg_data at the clock edge, only in IDLE.
- A write in the accept cycle takes effect before PROC uses that weight.
- cfg_we is ignored in PROC and DONE.
- Out-of-range neuron indices are ignored.
REQ-028 clr in IDLE SHALL zero all pot and msb_q at the next edge and block acceptance that cycle; clr in PROC/DONE is ignored.
REQ-029 in_valid while in_ready=0 SHALL NOT be accepted; the upstream holds the request.

Reset
REQ-030 nRST low SHALL asynchronously force:
- state=IDLE, neuron index=0;
- all pot, msb_q and weights=0;
- out_spikes=0, out_valid=0, ts_count=0;
- in_ready=1 once nRST is released.
REQ-031 Reset asserted during PROC SHALL abort the timestep with no out_valid pulse.

Verification
REQ-032 Set w[0][0..3]=+7, others 0; apply in_spikes=4'b1111 for 4 timesteps.
- pot[0] per step: 28, 56, 0, 28.
- out_spikes[0] per step: 0, 0, 1, 0.
REQ-033 Set w[1][0]=-8; apply in_spikes=4'b0001 for 2 timesteps.
- pot[1] goes to 56, then 0.
- out_spikes[1] = 0, then 1.
REQ-034 N_NEURONS=4: accept at cycle T.
- out_valid is high only in cycle T+5.
- in_ready is low in cycles T+1..T+5.
- ts_count increments by 1.
REQ-035 Assert cfg_we during PROC with data 7 -> the weight is unchanged; the next timestep's sum matches the old weight.
REQ-036 Assert nRST mid-PROC -> all outputs are 0 within the reset cycle, no out_valid pulse, and a subsequent timestep with zero weights gives out_spikes=0.
REQ-037 Pulse clr in IDLE after REQ-032 step 2 -> pot=0 and msb_q=0; next step pot[0]=28 with no spike.
